// File: rtl/adder_module_pkg.sv
// Shared binary16 constants, rounding-mode encodings, flag positions and
// helpers for the three-input tree adder.
package adder_module_pkg;

  localparam int CTRL_W = 1;
  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;
  localparam int SIG_W  = FRAC_W + 1;
  // Fixed-point width that holds any finite binary16 in units of 2^-24.
  localparam int MAG_W  = SIG_W + 2 * BIAS;
  localparam int FLAG_W = 5;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

  typedef enum logic [2:0] {
    RM_NEAR_EVEN   = 3'b000,
    RM_MIN_MAG     = 3'b001,
    RM_MIN         = 3'b010,
    RM_MAX         = 3'b011,
    RM_NEAR_MAXMAG = 3'b100,
    RM_ODD         = 3'b110
  } rm_e;

  localparam int FLG_INEXACT   = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_INFINITE  = 3;
  localparam int FLG_INVALID   = 4;

  localparam logic [15:0] CANON_NAN  = 16'h7E00;
  localparam logic [15:0] MAX_FINITE = 16'h7BFF;
  localparam logic [15:0] POS_INF    = 16'h7C00;

  function automatic logic [MAG_W-1:0] to_mag(input logic [14:0] m);
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] sh;
    e  = m[14:10];
    sh = (e == '0) ? EXP_W'(0) : e - EXP_W'(1);
    return MAG_W'({e != '0, m[9:0]}) << sh;
  endfunction

  function automatic logic [5:0] lead_one(input logic [MAG_W-1:0] v);
    logic [5:0] p;
    p = '0;
    for (int i = 0; i < MAG_W; i++)
      if (v[i]) p = 6'(i);
    return p;
  endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational binary16 adder: exact fixed-point sum, one rounding step.
// Flags are produced only when ADDER_MODULE_FLAGS_EN is defined.
module fp16_add
  import adder_module_pkg::*;
(
  input  logic [CTRL_W-1:0] control_i,
  input  logic [2:0]        rm_i,
  input  logic [15:0]       a_i,
  input  logic [15:0]       b_i,
  output logic [15:0]       res_o,
  output logic [FLAG_W-1:0] flags_o
);

  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;

  assign {sa, ea, fa} = a_i;
  assign {sb, eb, fb} = b_i;

  logic a_nan, b_nan, a_inf, b_inf, inf_clash;

  assign a_nan     = (ea == EXP_MAX) && (fa != '0);
  assign b_nan     = (eb == EXP_MAX) && (fb != '0);
  assign a_inf     = (ea == EXP_MAX) && (fa == '0);
  assign b_inf     = (eb == EXP_MAX) && (fb == '0);
  assign inf_clash = a_inf && b_inf && (sa != sb);

  logic [MAG_W-1:0] ma, mb, mag;
  logic             sgn;

  assign ma = to_mag(a_i[14:0]);
  assign mb = to_mag(b_i[14:0]);

  always_comb begin
    mag = '0;
    sgn = sa;
    if (sa == sb) begin
      mag = ma + mb;
    end else if (ma >= mb) begin
      mag = ma - mb;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    // Exact cancellation: +0 except when rounding toward -inf.
    if ((mag == '0) && (sa != sb))
      sgn = (rm_i == RM_MIN);
  end

  logic [5:0]       p, sh, e_pre, e_post;
  logic [MAG_W-1:0] lo_mask;
  logic [SIG_W-1:0] kept;
  logic             rnd, sticky, inexact, inc;

  assign p       = lead_one(mag);
  assign sh      = (p > 6'd10) ? p - 6'd10 : 6'd0;
  assign e_pre   = (p >= 6'd10) ? p - 6'd9 : 6'd0;
  assign lo_mask = (MAG_W'(1) << sh) - MAG_W'(1);
  assign kept    = SIG_W'(mag >> sh);
  assign rnd     = |(mag & (lo_mask ^ (lo_mask >> 1)));
  assign sticky  = |(mag & (lo_mask >> 1));
  assign inexact = rnd | sticky;

  always_comb begin
    inc = 1'b0;
    case (rm_i)
      RM_MIN_MAG,
      RM_ODD:         inc = 1'b0;
      RM_MIN:         inc = sgn & inexact;
      RM_MAX:         inc = ~sgn & inexact;
      RM_NEAR_MAXMAG: inc = rnd;
      default:        inc = rnd & (sticky | kept[0]);
    endcase
  end

  logic [SIG_W:0]    sum_r;
  logic [FRAC_W-1:0] frac;
  logic              jam, ovf, ovf_inf;

  assign sum_r  = {1'b0, kept} + {{SIG_W{1'b0}}, inc};
  assign jam    = (rm_i == RM_ODD) && inexact;
  assign frac   = sum_r[SIG_W] ? sum_r[FRAC_W:1]
                               : {sum_r[FRAC_W-1:1], sum_r[0] | jam};
  assign e_post = e_pre + {5'd0, sum_r[SIG_W]};
  assign ovf    = (e_post >= 6'd31);

  always_comb begin
    ovf_inf = 1'b1;
    case (rm_i)
      RM_MIN_MAG,
      RM_ODD:  ovf_inf = 1'b0;
      RM_MIN:  ovf_inf = sgn;
      RM_MAX:  ovf_inf = ~sgn;
      default: ovf_inf = 1'b1;
    endcase
  end

  always_comb begin
    res_o = {sgn, e_post[EXP_W-1:0], frac};
    if (ovf)
      res_o = {sgn, ovf_inf ? POS_INF[14:0] : MAX_FINITE[14:0]};
    if (a_inf)
      res_o = {sa, POS_INF[14:0]};
    else if (b_inf)
      res_o = {sb, POS_INF[14:0]};
    if (a_nan || b_nan || inf_clash)
      res_o = CANON_NAN;
  end

`ifdef ADDER_MODULE_FLAGS_EN
  logic a_snan, b_snan, fin, tiny;

  assign a_snan = a_nan && !fa[FRAC_W-1];
  assign b_snan = b_nan && !fb[FRAC_W-1];
  assign fin    = !(a_nan || b_nan || a_inf || b_inf);
  assign tiny   = control_i[0] ? (e_post == '0) : (e_pre == '0);

  always_comb begin
    flags_o                = '0;
    flags_o[FLG_INVALID]   = a_snan || b_snan || inf_clash;
    flags_o[FLG_INFINITE]  = 1'b0;
    flags_o[FLG_OVERFLOW]  = fin && ovf;
    flags_o[FLG_UNDERFLOW] = fin && tiny && inexact;
    flags_o[FLG_INEXACT]   = fin && (inexact || ovf);
  end
`else
  logic unused_ctl;
  assign unused_ctl = ^control_i;
  assign flags_o    = '0;
`endif

endmodule

// File: rtl/adder_module.sv
// Registered binary16 tree sum (a +/- b) + (c +/- d), one-cycle latency.
// ADDER_MODULE_FLAGS_EN enables exceptionFlags; otherwise they read zero.
module adder_module
  import adder_module_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] control,
  input  logic [2:0]        subOp,
  input  logic [15:0]       a,
  input  logic [15:0]       b,
  input  logic [15:0]       c,
  input  logic [15:0]       d,
  input  logic [2:0]        roundingMode,
  output logic [15:0]       out,
  output logic [FLAG_W-1:0] exceptionFlags
);

  logic [15:0]       b_n, c_n, d_n;
  logic [15:0]       s0, s1, out_d, out_q;
  logic [FLAG_W-1:0] fl0, fl1, fl2, flags_d, flags_q;

  // Negation is a pure sign flip, NaNs included.
  assign b_n = b ^ {subOp[2], 15'd0};
  assign c_n = c ^ {subOp[1], 15'd0};
  assign d_n = d ^ {subOp[0], 15'd0};

  fp16_add u_s0 (
    .control_i (control),
    .rm_i      (roundingMode),
    .a_i       (a),
    .b_i       (b_n),
    .res_o     (s0),
    .flags_o   (fl0)
  );

  fp16_add u_s1 (
    .control_i (control),
    .rm_i      (roundingMode),
    .a_i       (c_n),
    .b_i       (d_n),
    .res_o     (s1),
    .flags_o   (fl1)
  );

  fp16_add u_s2 (
    .control_i (control),
    .rm_i      (roundingMode),
    .a_i       (s0),
    .b_i       (s1),
    .res_o     (out_d),
    .flags_o   (fl2)
  );

`ifdef ADDER_MODULE_FLAGS_EN
  assign flags_d = fl0 | fl1 | fl2;
`else
  logic unused_flags;
  assign unused_flags = ^{fl0, fl1, fl2};
  assign flags_d      = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign out            = out_q;
  assign exceptionFlags = flags_q;

endmodule

// File: tb/tb_adder_module.sv
// Bench for adder_module: directed cases plus random ops vs a real-valued model.
`timescale 1ns/1ps
module tb_adder_module;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:0]  control;
  logic [2:0]  subOp, roundingMode;
  logic [15:0] a, b, c, d, out;
  logic [4:0]  exceptionFlags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_module dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .control        (control),
    .subOp          (subOp),
    .a              (a),
    .b              (b),
    .c              (c),
    .d              (d),
    .roundingMode   (roundingMode),
    .out            (out),
    .exceptionFlags (exceptionFlags)
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] xf(input logic [4:0] f);
    logic [4:0] r;
    r = '0;
`ifdef ADDER_MODULE_FLAGS_EN
    r = f;
`endif
    return r;
  endfunction

  function automatic real p2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v;
    if (h[14:10] == 5'd0) v = real'(h[9:0]) * p2(-24);
    else v = (1024.0 + real'(h[9:0])) * p2(int'(h[14:10]) - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r, input bit neg);
    int e;
    logic [15:0] h;
    if (r < p2(-14)) begin
      h = {neg, 5'd0, 10'(longint'(r / p2(-24)))};
    end else begin
      e = -14;
      while (r >= p2(e + 1)) e++;
      h = {neg, 5'(e + 15), 10'(longint'(r / p2(e) * 1024.0) - 1024)};
    end
    return h;
  endfunction

  // One IEEE addition done with reals, then rounded to binary16.
  function automatic logic [20:0] ref_add(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic [2:0] rm);
    bit xn, yn, xs, ys, xi, yi, neg, inx, up, big, tiny;
    real s, m, q, fr, rv;
    longint n;
    int e;
    xn = (x[14:10] == 5'h1F) && (x[9:0] != 0);
    yn = (y[14:10] == 5'h1F) && (y[9:0] != 0);
    xs = xn && !x[9];
    ys = yn && !y[9];
    xi = x[14:0] == 15'h7C00;
    yi = y[14:0] == 15'h7C00;
    if (xn || yn) return {(xs || ys) ? 5'b10000 : 5'b00000, 16'h7E00};
    if (xi && yi && (x[15] != y[15])) return {5'b10000, 16'h7E00};
    if (xi) return {5'b0, x};
    if (yi) return {5'b0, y};
    s = h2r(x) + h2r(y);
    if (s == 0.0)
      return {5'b0, (x[15] == y[15]) ? x[15] : (rm == 3'b010), 15'd0};
    neg  = s < 0.0;
    m    = neg ? -s : s;
    tiny = m < p2(-14);
    if (tiny) q = p2(-24);
    else begin
      e = -14;
      while (m >= p2(e + 1)) e++;
      q = p2(e - 10);
    end
    n   = longint'($floor(m / q));
    fr  = m / q - real'(n);
    inx = fr != 0.0;
    case (rm)
      3'b001:  up = 1'b0;
      3'b010:  up = neg && inx;
      3'b011:  up = !neg && inx;
      3'b100:  up = fr >= 0.5;
      3'b110:  up = inx && !n[0];
      default: up = (fr > 0.5) || ((fr == 0.5) && n[0]);
    endcase
    if (up) n++;
    rv = real'(n) * q;
    if (rv >= 65536.0) begin
      case (rm)
        3'b001, 3'b110: big = 1'b0;
        3'b010:         big = neg;
        3'b011:         big = !neg;
        default:        big = 1'b1;
      endcase
      return {5'b00101, neg, big ? 15'h7C00 : 15'h7BFF};
    end
    return {3'b000, tiny && inx, inx, r2h(rv, neg)};
  endfunction

  function automatic logic [20:0] ref_top(input logic [15:0] ta, tb_, tc, td,
                                          input logic [2:0] so, rm);
    logic [20:0] s0, s1, r;
    s0 = ref_add(ta, tb_ ^ {so[2], 15'd0}, rm);
    s1 = ref_add(tc ^ {so[1], 15'd0}, td ^ {so[0], 15'd0}, rm);
    r  = ref_add(s0[15:0], s1[15:0], rm);
    return {s0[20:16] | s1[20:16] | r[20:16], r[15:0]};
  endfunction

  function automatic logic [15:0] rnd_h();
    logic [31:0] r;
    logic [15:0] h;
    r = $urandom;
    case (r[31:28])
      4'd0: begin
        case (r[2:0])
          3'd0: h = 16'h0000;
          3'd1: h = 16'h8000;
          3'd2: h = 16'h7C00;
          3'd3: h = 16'hFC00;
          3'd4: h = 16'h7E00;
          3'd5: h = 16'h7D00;
          3'd6: h = 16'h7BFF;
          default: h = 16'h0001;
        endcase
      end
      4'd1, 4'd2: h = {r[15], 2'b01, r[12:0]};
      4'd3:       h = {r[15], 4'b0000, r[10:0]};
      4'd4:       h = {r[15], 4'b1111, r[10:0]};
      default:    h = r[15:0];
    endcase
    return h;
  endfunction

  task automatic run(input string tag,
                     input logic [15:0] ta, tb_, tc, td,
                     input logic [2:0] so, rm,
                     input logic [15:0] eo, input logic [4:0] ef);
    a = ta; b = tb_; c = tc; d = td;
    subOp = so; roundingMode = rm;
    @(posedge clk);
    #1;
    check({tag, ".out"}, out, eo);
    check({tag, ".flg"}, {11'd0, exceptionFlags}, {11'd0, xf(ef)});
  endtask

  initial begin
    rst_n = 1'b1;
    control = '0;
    subOp = 3'b000; roundingMode = 3'b000;
    a = 16'h3C00; b = 16'h3C00; c = 16'h3C00; d = 16'h3C00;
    #1 rst_n = 1'b0;
    #1;
    check("rst0.out", out, 16'h0000);
    check("rst0.flg", {11'd0, exceptionFlags}, 16'h0000);
    @(posedge clk);
    #1;
    check("rst1.out", out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    run("sum1", 16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 3'b000, 3'b000, 16'h4000, 5'b0);
    run("sum2", 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 3'b000, 3'b000, 16'h4400, 5'b0);
    run("sum3", 16'h4000, 16'h4000, 16'h3C00, 16'h0000, 3'b000, 3'b000, 16'h4500, 5'b0);
    run("can1", 16'h4200, 16'hC200, 16'h0000, 16'h0000, 3'b000, 3'b000, 16'h0000, 5'b0);
    run("can2", 16'h4200, 16'h4200, 16'h0000, 16'h0000, 3'b100, 3'b000, 16'h0000, 5'b0);
    run("can3", 16'h3C00, 16'hBC00, 16'h0000, 16'h0000, 3'b000, 3'b000, 16'h0000, 5'b0);
    run("neg1", 16'h3C00, 16'hBC00, 16'h0000, 16'h0000, 3'b100, 3'b000, 16'h4000, 5'b0);
    run("neg2", 16'h3C00, 16'h4000, 16'h4500, 16'h4B00, 3'b101, 3'b000, 16'hC900, 5'b0);
    run("mix",  16'h4880, 16'h3C00, 16'h3800, 16'h3400, 3'b000, 3'b000, 16'h4960, 5'b0);
    run("infi", 16'h7C00, 16'h7C00, 16'h0000, 16'h0000, 3'b100, 3'b000, 16'h7E00, 5'b10000);
    run("ovf",  16'h7BFF, 16'h7BFF, 16'h0000, 16'h0000, 3'b000, 3'b000, 16'h7C00, 5'b00101);
    run("ovfmm", 16'h7BFF, 16'h7BFF, 16'h0000, 16'h0000, 3'b000, 3'b001, 16'h7BFF, 5'b00101);
    run("ovfmn", 16'hFBFF, 16'hFBFF, 16'h0000, 16'h0000, 3'b000, 3'b010, 16'hFC00, 5'b00101);
    run("canmin", 16'h4200, 16'hC200, 16'h0000, 16'h0000, 3'b000, 3'b010, 16'h8000, 5'b0);
    run("snan", 16'h7D00, 16'h3C00, 16'h0000, 16'h0000, 3'b000, 3'b000, 16'h7E00, 5'b10000);
    run("qnan", 16'h7E01, 16'h3C00, 16'h0000, 16'h0000, 3'b000, 3'b000, 16'h7E00, 5'b0);
    run("sub",  16'h0001, 16'h0001, 16'h0000, 16'h0000, 3'b000, 3'b000, 16'h0002, 5'b0);
    run("subn", 16'h03FF, 16'h0001, 16'h0000, 16'h0000, 3'b000, 3'b000, 16'h0400, 5'b0);
    run("tie",  16'h3C00, 16'h1000, 16'h0000, 16'h0000, 3'b000, 3'b000, 16'h3C00, 5'b00001);
    run("tiemx", 16'h3C00, 16'h1000, 16'h0000, 16'h0000, 3'b000, 3'b100, 16'h3C01, 5'b00001);
    run("tie5", 16'h3C00, 16'h1000, 16'h0000, 16'h0000, 3'b000, 3'b101, 16'h3C00, 5'b00001);
    run("tieodd", 16'h3C00, 16'h1000, 16'h0000, 16'h0000, 3'b000, 3'b110, 16'h3C01, 5'b00001);

    run("pre_rst", 16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 3'b000, 3'b000, 16'h4000, 5'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async.out", out, 16'h0000);
    check("rst_async.flg", {11'd0, exceptionFlags}, 16'h0000);
    a = 16'h7BFF; b = 16'h7BFF;
    @(posedge clk);
    #1;
    check("rst_hold.out", out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 16'h4000, 16'h4000, 16'h0000, 16'h0000, 3'b000, 3'b000, 16'h4400, 5'b0);

    for (int i = 0; i < 600; i++) begin
      logic [15:0] ra, rb, rc, rd;
      logic [2:0]  so, rm;
      logic [20:0] m;
      ra = rnd_h(); rb = rnd_h(); rc = rnd_h(); rd = rnd_h();
      if ($urandom_range(0, 3) == 0)
        rb = ra ^ 16'h8000 ^ 16'($urandom_range(0, 3));
      so = 3'($urandom);
      rm = 3'($urandom);
      control = 1'($urandom);
      m = ref_top(ra, rb, rc, rd, so, rm);
      run($sformatf("rnd%0d", i), ra, rb, rc, rd, so, rm, m[15:0], m[20:16]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_module.md
ADDER_MODULE -- requirements
Module: adder_module

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 control  input  `floatControlWidth (1)  bit0 = tininess detection: 0 before rounding, 1 after rounding (HardFloat encoding).
REQ-004 subOp  input  3  per-operand negate: bit2 negates b, bit1 negates c, bit0 negates d.
REQ-005 a, b, c, d  input  16 each  IEEE 754 binary16 operands.
REQ-006 roundingMode  input  3  HardFloat encoding:
- 000 near_even
- 001 minMag
- 010 min
- 011 max
- 100 near_maxMag
- 110 odd
REQ-007 out  output  16  binary16 result, registered.
REQ-008 exceptionFlags  output  5  {invalid, infinite, overflow, underflow, inexact}, registered.

Function
REQ-009 The result SHALL be out = (a ± b) + (c ± d), with sign selection per subOp.
REQ-010 Negation SHALL be a sign-bit flip only, applied to NaNs too.
REQ-011 Evaluation SHALL be a fixed tree:
- s0 = a ± b, rounded to binary16 with roundingMode.
- s1 = c ± d, rounded likewise.
- out = s0 + s1, rounded likewise.
REQ-012 Each adder stage SHALL be IEEE-754 correct for normals, subnormals, zeros and infinities.
REQ-013 An exact zero sum of opposite-signed operands SHALL be +0, except under roundingMode min, where it SHALL be -0.
REQ-014 Invalid operations SHALL produce canonical NaN 0x7E00 and raise invalid:
- +inf + -inf at any stage;
- any signaling NaN input.
REQ-015 A quiet NaN input SHALL produce 0x7E00 without raising invalid.
REQ-016 Overflow SHALL produce ±inf or ±max-finite (0x7BFF) per rounding mode, and SHALL raise overflow and inexact.
REQ-017 exceptionFlags SHALL be the bitwise OR of the three stage flag vectors; the infinite flag SHALL always be 0.
REQ-018 Latency SHALL be 1 cycle: inputs sampled on rising edge N appear on out/exceptionFlags after edge N.
REQ-019 There is no handshake; a new operation is accepted every cycle (throughput 1/cycle).
REQ-020 Unused roundingMode encodings (101, 111) SHALL behave as near_even.

Reset
REQ-021 While rst_n = 0, out SHALL be 16'h0000 and exceptionFlags SHALL be 5'b0, asynchronously.
REQ-022 Reset deassertion mid-stream SHALL discard any in-flight result.
REQ-023 The first valid output SHALL follow the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro ADDER_MODULE_FLAGS_EN SHALL control exception-flag generation:
- Defined: flags are computed per REQ-014 through REQ-017.
- Undefined: exceptionFlags is tied to 5'b0, flag logic is removed, and out is unchanged.

Structure
REQ-025 A shared package SHALL hold:
- binary16 field widths (exp 5, frac 10, bias 15);
- rounding-mode encodings;
- flag bit positions;
- canonical NaN constant 16'h7E00;
- max-finite constant 16'h7BFF.
REQ-026 One sub-module, fp16_add, SHALL be instantiated three times.
REQ-027 fp16_add SHALL be a combinational binary16 two-operand adder with rounding and a 5-bit flag output.
REQ-028 The top level SHALL contain only the sign flips, the three fp16_add instances, the flag OR and the output registers.

Verification (roundingMode 000, control 0, result checked one cycle after apply)
REQ-029 Basic sums SHALL match:
- a=3C00, b=3C00, c=0000, d=0000, subOp=000 -> out 4000.
- a=3C00, b=3C00, c=3C00, d=3C00, subOp=000 -> out 4400.
- a=4000, b=4000, c=3C00, d=0000 -> out 4500.
REQ-030 Cancellation SHALL give +0:
- a=4200, b=C200, subOp=000 -> out 0000.
- a=4200, b=4200, subOp=100 -> out 0000.
- a=3C00, b=BC00, subOp=000 -> out 0000.
REQ-031 Negated operands SHALL match:
- a=3C00, b=BC00, subOp=100 -> out 4000.
- a=3C00, b=4000, c=4500, d=4B00, subOp=101 -> out C900.
REQ-032 Mixed exponents SHALL match: a=4880, b=3C00, c=3800, d=3400 -> out 4960, flags 00000.
REQ-033 Exceptions SHALL match:
- a=7C00, b=7C00, subOp=100 -> out 7E00, invalid set.
- a=7BFF, b=7BFF -> out 7C00, flags overflow and inexact.
REQ-034 Reset SHALL override: assert rst_n=0 between clock edges -> out 0000 and flags 00000 immediately, without waiting for an edge.
